// File: rtl/request_debouncer_pkg.sv
// Constants shared by the button front end and the round-robin arbiter that consumes
// its request vector.
package request_debouncer_pkg;

   localparam int NUM_REQ_LINES           = 4;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
   localparam int CLK_FREQ_HZ             = 50000000;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } pend_state_t;

endpackage

// File: rtl/request_debouncer_debounce_channel.sv
// One button line: synchroniser chain, stability counter and a single-cycle press pulse
// on each accepted rising level.
module debounce_channel
   import request_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_press
);

   localparam int                 CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_stable;
   logic                   r_stable_d;
   logic [CNT_W-1:0]       r_cnt;
   logic                   w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync     <= '0;
         r_stable   <= 1'b0;
         r_stable_d <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_sync     <= {r_sync[SYNC_STAGES-2:0], i_btn};
         r_stable_d <= r_stable;
         // Any cycle of agreement restarts the count, so only an unbroken run is accepted.
         if (w_sync == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_stable <= w_sync;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_ONE;
         end
      end
   end

   assign o_press = r_stable & ~r_stable_d;

endmodule

// File: rtl/request_debouncer.sv
// Turns four bouncy buttons into sticky requests for the arbiter; each request is held
// until the arbiter's grant for that line falls.
module request_debouncer
   import request_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES       = 2,
   parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ_LINES-1:0] button_in,
   input  logic [NUM_REQ_LINES-1:0] grant_in,
   output logic [NUM_REQ_LINES-1:0] request_queue
);

   logic [NUM_REQ_LINES-1:0] w_btn_n;
   logic [NUM_REQ_LINES-1:0] w_press;
   logic [NUM_REQ_LINES-1:0] r_grant_d;
   logic [NUM_REQ_LINES-1:0] r_gdone;
   pend_state_t              r_state [NUM_REQ_LINES];

   assign w_btn_n = button_in ^ {NUM_REQ_LINES{BUTTON_ACTIVE_LOW}};

   for (genvar gi = 0; gi < NUM_REQ_LINES; gi++) begin : g_line
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES)
      ) u_channel (
         .clk     (clk),
         .reset   (reset),
         .i_btn   (w_btn_n[gi]),
         .o_press (w_press[gi])
      );

      assign request_queue[gi] = (r_state[gi] == PENDING);
   end

   // The grant-done event is registered, so a request drops on the second edge after
   // the arbiter's grant is first seen low.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant_d <= '0;
         r_gdone   <= '0;
         for (int i = 0; i < NUM_REQ_LINES; i++) begin
            r_state[i] <= IDLE;
         end
      end else begin
         r_grant_d <= grant_in;
         r_gdone   <= r_grant_d & ~grant_in;
         for (int i = 0; i < NUM_REQ_LINES; i++) begin
            case (r_state[i])
               IDLE:    if (w_press[i]) r_state[i] <= PENDING;
               PENDING: if (r_gdone[i] && !w_press[i]) r_state[i] <= IDLE;
               default: r_state[i] <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_request_debouncer.sv
// Bench for request_debouncer with a short debounce window; directed scenarios plus a
// randomized run against a cycle-level reference model of the request behaviour.
module tb_request_debouncer;

   localparam int D   = 4;
   localparam int S   = 2;
   localparam bit BAL = 1'b0;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] button_in = 4'b0000;
   logic [3:0] grant_in = 4'b0000;
   logic [3:0] request_queue;

   int errors = 0;
   int checks = 0;

   request_debouncer #(
      .DEBOUNCE_CYCLES   (D),
      .SYNC_STAGES       (S),
      .BUTTON_ACTIVE_LOW (BAL)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .button_in     (button_in),
      .grant_in      (grant_in),
      .request_queue (request_queue)
   );

   always #5 clk = ~clk;

   // Reference model: delayed samples of each button, length of the current run of
   // disagreement with the accepted level, and the request flag driven by press/done events.
   bit         m_dl    [4][S];
   int         m_run   [4];
   bit         m_st    [4];
   bit         m_stp   [4];
   bit         m_pend  [4];
   bit         m_gA    [4];
   bit         m_gB    [4];
   bit         m_press, m_gdone, m_seen;
   logic [3:0] m_q = 4'b0000;

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (reset) begin
            for (int j = 0; j < S; j++) m_dl[i][j] = 1'b0;
            m_run[i] = 0; m_st[i] = 1'b0; m_stp[i] = 1'b0;
            m_pend[i] = 1'b0; m_gA[i] = 1'b0; m_gB[i] = 1'b0;
         end else begin
            m_press = m_st[i] & ~m_stp[i];
            m_gdone = m_gB[i] & ~m_gA[i];
            if (m_press) m_pend[i] = 1'b1;
            else if (m_gdone) m_pend[i] = 1'b0;
            m_gB[i] = m_gA[i];
            m_gA[i] = grant_in[i];
            m_seen = m_dl[i][S-1];
            m_stp[i] = m_st[i];
            if (m_seen == m_st[i]) begin
               m_run[i] = 0;
            end else begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] == D) begin
                  m_st[i] = m_seen;
                  m_run[i] = 0;
               end
            end
            for (int j = S - 1; j > 0; j--) m_dl[i][j] = m_dl[i][j-1];
            m_dl[i][0] = button_in[i] ^ BAL;
         end
         m_q[i] = m_pend[i];
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; button_in = 4'b1111; grant_in = 4'b0000;
      step(3);
      checks++;
      if (request_queue !== 4'b0000) begin
         errors++; $display("FAIL reset_hold: got %b want %b", request_queue, 4'b0000);
      end
      reset = 1'b0;
      step(6);
      checks++;
      if (request_queue !== 4'b0000) begin
         errors++; $display("FAIL reset_release_edge6: got %b want %b", request_queue, 4'b0000);
      end
      step(1);
      checks++;
      if (request_queue !== 4'b1111) begin
         errors++; $display("FAIL reset_release_edge7: got %b want %b", request_queue, 4'b1111);
      end
      button_in = 4'b0000; grant_in = 4'b1111;
      step(2);
      grant_in = 4'b0000;
      step(2);
      step(8);
      checks++;
      if (request_queue !== 4'b0000) begin
         errors++; $display("FAIL reset_cleanup: got %b want %b", request_queue, 4'b0000);
      end
   endtask

   task automatic test_clean_press;
      button_in = 4'b0100;
      step(6);
      checks++;
      if (request_queue !== 4'b0000) begin
         errors++; $display("FAIL press_edge5: got %b want %b", request_queue, 4'b0000);
      end
      step(1);
      checks++;
      if (request_queue !== 4'b0100) begin
         errors++; $display("FAIL press_edge6: got %b want %b", request_queue, 4'b0100);
      end
      step(5);
      checks++;
      if (request_queue !== 4'b0100) begin
         errors++; $display("FAIL press_sticky: got %b want %b", request_queue, 4'b0100);
      end
      button_in = 4'b0000;
      step(8);
      checks++;
      if (request_queue !== 4'b0100) begin
         errors++; $display("FAIL release_no_effect: got %b want %b", request_queue, 4'b0100);
      end
      grant_in = 4'b0100;
      step(1);
      grant_in = 4'b0000;
      step(2);
      checks++;
      if (request_queue !== 4'b0000) begin
         errors++; $display("FAIL press_cleared: got %b want %b", request_queue, 4'b0000);
      end
   endtask

   task automatic test_bounce;
      bit pat [14] = '{1,1,1,0,1,1,1,0,0,0,0,0,0,0};
      for (int k = 0; k < 14; k++) begin
         button_in = {3'b000, pat[k]};
         step(1);
         checks++;
         if (request_queue !== 4'b0000) begin
            errors++; $display("FAIL bounce_step%0d: got %b want %b", k, request_queue, 4'b0000);
         end
      end
      button_in = 4'b0001;
      step(6);
      checks++;
      if (request_queue !== 4'b0000) begin
         errors++; $display("FAIL bounce_hold_edge5: got %b want %b", request_queue, 4'b0000);
      end
      step(1);
      checks++;
      if (request_queue !== 4'b0001) begin
         errors++; $display("FAIL bounce_hold_accept: got %b want %b", request_queue, 4'b0001);
      end
   endtask

   task automatic test_grant_clear;
      grant_in = 4'b0001;
      for (int k = 0; k < 10; k++) begin
         step(1);
         checks++;
         if (request_queue !== 4'b0001) begin
            errors++; $display("FAIL grant_held_c%0d: got %b want %b", k, request_queue, 4'b0001);
         end
      end
      grant_in = 4'b0000;
      step(1);
      checks++;
      if (request_queue !== 4'b0001) begin
         errors++; $display("FAIL grant_drop_edge1: got %b want %b", request_queue, 4'b0001);
      end
      step(1);
      checks++;
      if (request_queue !== 4'b0000) begin
         errors++; $display("FAIL grant_drop_edge2: got %b want %b", request_queue, 4'b0000);
      end
      button_in = 4'b0000;
      step(8);
   endtask

   task automatic test_simultaneous;
      button_in = 4'b1000;
      step(7);
      checks++;
      if (request_queue !== 4'b1000) begin
         errors++; $display("FAIL simul_setup: got %b want %b", request_queue, 4'b1000);
      end
      button_in = 4'b0000;
      step(8);
      grant_in = 4'b1000;
      step(3);
      button_in = 4'b1000;
      step(5);
      grant_in = 4'b0000;
      step(1);
      checks++;
      if (request_queue !== 4'b1000) begin
         errors++; $display("FAIL simul_edge5: got %b want %b", request_queue, 4'b1000);
      end
      step(1);
      checks++;
      if (request_queue !== 4'b1000) begin
         errors++; $display("FAIL simul_edge6: got %b want %b", request_queue, 4'b1000);
      end
      step(4);
      checks++;
      if (request_queue !== 4'b1000) begin
         errors++; $display("FAIL simul_after: got %b want %b", request_queue, 4'b1000);
      end
      button_in = 4'b0000;
      step(8);
      grant_in = 4'b1000;
      step(1);
      grant_in = 4'b0000;
      step(2);
      checks++;
      if (request_queue !== 4'b0000) begin
         errors++; $display("FAIL simul_cleanup: got %b want %b", request_queue, 4'b0000);
      end
   endtask

   task automatic test_reset_mid;
      button_in = 4'b1010;
      step(7);
      checks++;
      if (request_queue !== 4'b1010) begin
         errors++; $display("FAIL mid_setup: got %b want %b", request_queue, 4'b1010);
      end
      button_in = 4'b1111;
      step(3);
      reset = 1'b1;
      step(1);
      checks++;
      if (request_queue !== 4'b0000) begin
         errors++; $display("FAIL mid_reset: got %b want %b", request_queue, 4'b0000);
      end
      reset = 1'b0;
      step(6);
      checks++;
      if (request_queue !== 4'b0000) begin
         errors++; $display("FAIL mid_restart_edge6: got %b want %b", request_queue, 4'b0000);
      end
      step(1);
      checks++;
      if (request_queue !== 4'b1111) begin
         errors++; $display("FAIL mid_restart_edge7: got %b want %b", request_queue, 4'b1111);
      end
      button_in = 4'b0000; grant_in = 4'b1111;
      step(2);
      grant_in = 4'b0000;
      step(2);
      step(8);
   endtask

   task automatic test_random;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 9) == 0) button_in[i] = ~button_in[i];
            if ($urandom_range(0, 7) == 0) grant_in[i] = ~grant_in[i];
         end
         step(1);
         checks++;
         if (request_queue !== m_q) begin
            errors++; $display("FAIL random_c%0d: got %b want %b", c, request_queue, m_q);
         end
      end
   endtask

   initial begin
      test_reset;
      test_clean_press;
      test_bounce;
      test_grant_clear;
      test_simultaneous;
      test_reset_mid;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/request_debouncer.md
# request_debouncer

Front-end conditioner that turns four raw push-button inputs into the clean, sticky `request_queue[3:0]` consumed by the round-robin arbiter.
- Per line: synchronises the asynchronous button, debounces it with a stability counter, and converts each press into a pending request.
- A pending request is held until the arbiter has finished servicing that line, signalled by the falling edge of the line's `grant_in` bit.
- Sits between the board buttons and the arbiter; runs on the same 50 MHz clock.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a new level (20 ms at 50 MHz); legal range ≥ 1.
- `SYNC_STAGES`, default 2: synchroniser depth; legal range ≥ 2.
- `BUTTON_ACTIVE_LOW`, default 1: 1 inverts `button_in` before synchronisation.
- `clk` input 1: system clock. One clock domain.
- `reset` input 1: synchronous, active-high reset.
- `button_in` input 4: raw, asynchronous, bouncy buttons; bit i maps to request line i+1.
- `grant_in` input 4: arbiter `grant_out`, fed back.
- `request_queue` output 4: pending requests to the arbiter.

## Operation
- **Normalisation:** `btn_n[i] = button_in[i] ^ BUTTON_ACTIVE_LOW`.
- **Synchroniser:** `btn_n[i]` passes through a `SYNC_STAGES`-deep flop chain; the last stage is `sync[i]`.
- **Debounce (per line):**
  - Registers: `stable[i]` and `cnt[i]`, with `cnt` width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `sync == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Any single-cycle agreement between `sync` and `stable` restarts the count.
- **Press event:** `press[i] = stable[i] & ~stable_d[i]`, where `stable_d` is `stable` delayed one cycle. Release edges generate nothing.
- **Grant-done event:** `gdone[i] = grant_d[i] & ~grant_in[i]`, where `grant_d` is a registered copy of `grant_in`.
- **Pending flag, per line, two states (IDLE = 0, PENDING = 1):**
  - IDLE → PENDING on `press`.
  - PENDING → IDLE on `gdone` without `press`.
  - If `press` and `gdone` occur in the same cycle, the result is PENDING (the new press wins).
  - A `press` while already PENDING has no effect; requests do not queue beyond one.
- **Output:** `request_queue = pending`, registered with no combinational path from inputs.
- **Independence:** the four lines are fully independent.

## Timing
- **Reset:** clears all sync flops, `stable`, `stable_d`, `cnt`, `grant_d` and `pending`. `request_queue` = 4'b0000 on the cycle after the reset edge.
- **Reset mid-operation:** discards all pending requests and partial counts. Buttons held through reset are re-accepted as a press `SYNC_STAGES + DEBOUNCE_CYCLES + 1` edges after reset deasserts.
- **Press latency:** let edge 0 be the first clock edge that samples the new button level.
  - `sync` changes at edge `SYNC_STAGES-1`.
  - `stable` changes at edge `SYNC_STAGES+DEBOUNCE_CYCLES-1`.
  - `request_queue[i]` rises at edge `SYNC_STAGES+DEBOUNCE_CYCLES`.
- **Clear latency:** `request_queue[i]` falls at the second clock edge after `grant_in[i]` is first sampled low, i.e. edge k+1 when the first low sample is at edge k.
- **Grant pulses:** a `grant_in` pulse of any length ≥ 1 cycle clears the request on its falling edge. `grant_in` held high changes nothing.
- **Counter bound:** `cnt` never exceeds `DEBOUNCE_CYCLES-1`; no wrap-around.

## Structure
- Shared package/header holds:
  - `NUM_REQ_LINES = 4`
  - `DEFAULT_DEBOUNCE_CYCLES = 1000000`
  - `CLK_FREQ_HZ = 50000000`
- The arbiter uses the same package for its request width.
- Sub-module `debounce_channel`: one line covering sync chain, counter, `stable`/`stable_d` and a `press` output. It is instantiated 4× with a generate loop.
- The top level holds `grant_d`, `pending` and the event logic.

## Test plan
All directed tests use bench parameters `DEBOUNCE_CYCLES=4`, `SYNC_STAGES=2`, `BUTTON_ACTIVE_LOW=0`.
- **Reset:** `reset` high with `button_in`=4'b1111 → `request_queue`=0000. After release, `request_queue`=1111 exactly 7 edges later.
- **Clean press:** `button_in[2]` rises and holds → `request_queue`=0100 at edge 6 after the first high sample. Other bits stay 0.
- **Bounce rejection:** `button_in[0]` toggles high 3 cycles, low 1, high 3, low → `request_queue` stays 0000. Holding high 4+ cycles sets bit 0.
- **Grant clear:** with `request_queue`=0001, drive `grant_in`=0001 for 10 cycles then 0000 → bit 0 remains 1 while granted and falls 2 edges after `grant_in` drops.
- **Simultaneous events:** line 3 `stable` rising edge in the same cycle as the `grant_in[3]` falling edge → `request_queue[3]` stays 1.
- **Reset mid-operation:** assert reset with `request_queue`=1010 and counters mid-count → 0000 next cycle, all counters restart from 0.
